// File: rtl/stg_4_me.sv
// stg_4_me: memory stage of the in-order pipeline.
// Takes the EX->ME registers (r_me_*), runs the data-memory access over a
// req/ack handshake, queues print values in a small FIFO drained through a
// valid/ready port, and produces the ME->WB registers (r_wb_*).
// stall_o tells upstream to hold while the access or a print push is pending.
// Optional feature: define STG_ME_ACK_TIMEOUT_EN to add an ack watchdog and
// the sticky mem_err output.
module stg_4_me #(
  parameter int VALUE_W     = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int PRINT_DEPTH = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] r_me_rd,
  input  logic [VALUE_W-1:0]    r_me_aluout,
  input  logic                  r_me_aluzero,
  input  logic [VALUE_W-1:0]    r_me_store,
  input  logic                  r_me_RegWrite,
  input  logic                  r_me_PrintValue,
  input  logic                  r_me_MemRead,
  input  logic                  r_me_MemWrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [VALUE_W-1:0]    dmem_addr,
  output logic [VALUE_W-1:0]    dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [VALUE_W-1:0]    dmem_rdata,
  output logic                  stall_o,
  output logic                  print_valid,
  output logic [VALUE_W-1:0]    print_data,
  input  logic                  print_ready,
  output logic [REG_ADDR_W-1:0] r_wb_rd,
  output logic [VALUE_W-1:0]    r_wb_value,
  output logic                  r_wb_aluzero,
  output logic                  r_wb_RegWrite
`ifdef STG_ME_ACK_TIMEOUT_EN
  ,
  output logic                  mem_err
`endif
);

  localparam int PTR_W = $clog2(PRINT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;

  // Access completed while the print push was blocked: data kept here so
  // the request is not issued a second time.
  logic                 done_r;
  logic [VALUE_W-1:0]   rdata_hold_r;

  logic [VALUE_W-1:0]   fifo_mem_r [PRINT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 mem_op_s;
  logic                 is_load_s;
  logic                 need_req_s;
  logic                 mem_ok_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 print_block_s;
  logic                 abort_s;
  logic                 retire_s;
  logic                 normal_retire_s;
  logic [VALUE_W-1:0]   wb_value_s;

`ifdef STG_ME_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]      tmo_cnt_r;
  logic                 mem_err_r;
`endif

  // Handshake, stall and retire decode for the instruction in this stage.
  always_comb begin
    mem_op_s    = r_me_MemRead | r_me_MemWrite;
    // A combined read+write is treated as a store: no load data returned.
    is_load_s   = r_me_MemRead & ~r_me_MemWrite;
    need_req_s  = mem_op_s & ~done_r;
    mem_ok_s    = ~mem_op_s | done_r | dmem_ack;
    print_valid = (count_r != {CNT_W{1'b0}});
    full_s      = (count_r == CNT_W'(PRINT_DEPTH));
    pop_s       = print_valid & print_ready;
    // A pop in the same cycle frees the slot for this push.
    print_block_s = r_me_PrintValue & full_s & ~pop_s;
`ifdef STG_ME_ACK_TIMEOUT_EN
    abort_s = (state_r == WAIT) & need_req_s & ~dmem_ack &
              (tmo_cnt_r == TO_W'(TIMEOUT_CYC - 1));
`else
    abort_s = 1'b0;
`endif
    // An aborted access retires as a bubble, so it never waits on the FIFO.
    stall_o         = ~abort_s & (~mem_ok_s | print_block_s);
    retire_s        = ~stall_o;
    normal_retire_s = retire_s & ~abort_s;
    push_s          = normal_retire_s & r_me_PrintValue;
    if (is_load_s) begin
      wb_value_s = done_r ? rdata_hold_r : dmem_rdata;
    end else begin
      wb_value_s = r_me_aluout;
    end
  end

  // Memory port: request follows the pending access and drops with reset.
  always_comb begin
    dmem_req   = need_req_s & reset;
    dmem_we    = r_me_MemWrite;
    dmem_addr  = r_me_aluout;
    dmem_wdata = r_me_store;
  end

  // Next-state logic for the IDLE/WAIT access FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (need_req_s & ~dmem_ack) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (abort_s | ~need_req_s | dmem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch an access that completes while the stage is still stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_r       <= 1'b0;
      rdata_hold_r <= {VALUE_W{1'b0}};
    end else if (retire_s) begin
      done_r       <= 1'b0;
    end else if (need_req_s & dmem_ack) begin
      done_r       <= 1'b1;
      rdata_hold_r <= dmem_rdata;
    end
  end

  // ME->WB registers: load on retire, bubble on stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_rd       <= {REG_ADDR_W{1'b0}};
      r_wb_value    <= {VALUE_W{1'b0}};
      r_wb_aluzero  <= 1'b0;
      r_wb_RegWrite <= 1'b0;
    end else if (retire_s) begin
      r_wb_rd       <= r_me_rd;
      r_wb_value    <= wb_value_s;
      r_wb_aluzero  <= r_me_aluzero;
      r_wb_RegWrite <= r_me_RegWrite & ~abort_s;
    end else begin
      r_wb_RegWrite <= 1'b0;
    end
  end

  // Print FIFO storage and pointers; pointers wrap at PRINT_DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PRINT_DEPTH; i++) begin
        fifo_mem_r[i] <= {VALUE_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= wb_value_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Print FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of the FIFO; zero while empty.
  always_comb begin
    if (print_valid) begin
      print_data = fifo_mem_r[rd_ptr_r];
    end else begin
      print_data = {VALUE_W{1'b0}};
    end
  end

`ifdef STG_ME_ACK_TIMEOUT_EN
  // Ack watchdog: counts consecutive WAIT cycles without an ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == WAIT) & ~dmem_ack & ~abort_s) begin
      tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
    end else begin
      tmo_cnt_r <= {TO_W{1'b0}};
    end
  end

  // Sticky error flag set by a watchdog abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_err_r <= 1'b0;
    end else if (abort_s) begin
      mem_err_r <= 1'b1;
    end else begin
      mem_err_r <= mem_err_r;
    end
  end

  assign mem_err = mem_err_r;
`endif

endmodule

// File: tb/tb_stg_4_me.sv
// Scoreboard bench for stg_4_me: directed stimulus pushes expected writeback
// and print values into queues; a negedge monitor pops and compares them
// whenever the DUT retires a RegWrite instruction or pops the print FIFO.
module tb_stg_4_me;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  r_me_rd;
  logic [31:0] r_me_aluout;
  logic        r_me_aluzero;
  logic [31:0] r_me_store;
  logic        r_me_RegWrite;
  logic        r_me_PrintValue;
  logic        r_me_MemRead;
  logic        r_me_MemWrite;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_o;
  logic        print_valid;
  logic [31:0] print_data;
  logic        print_ready;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_value;
  logic        r_wb_aluzero;
  logic        r_wb_RegWrite;
`ifdef STG_ME_ACK_TIMEOUT_EN
  logic        mem_err;
`endif

  stg_4_me #(
    .VALUE_W(32), .REG_ADDR_W(5), .PRINT_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clock(clock), .reset(reset),
    .r_me_rd(r_me_rd), .r_me_aluout(r_me_aluout), .r_me_aluzero(r_me_aluzero),
    .r_me_store(r_me_store), .r_me_RegWrite(r_me_RegWrite),
    .r_me_PrintValue(r_me_PrintValue), .r_me_MemRead(r_me_MemRead),
    .r_me_MemWrite(r_me_MemWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .print_valid(print_valid), .print_data(print_data),
    .print_ready(print_ready),
    .r_wb_rd(r_wb_rd), .r_wb_value(r_wb_value), .r_wb_aluzero(r_wb_aluzero),
    .r_wb_RegWrite(r_wb_RegWrite)
`ifdef STG_ME_ACK_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
    logic        zero;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] pr_q[$];
  wb_t         mon_wb;
  logic [31:0] mon_pr;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [31:0] alu, input logic zero,
                           input logic [31:0] st, input logic rw, input logic pv,
                           input logic mr, input logic mw);
    r_me_rd = rd; r_me_aluout = alu; r_me_aluzero = zero; r_me_store = st;
    r_me_RegWrite = rw; r_me_PrintValue = pv; r_me_MemRead = mr; r_me_MemWrite = mw;
  endtask

  task automatic nop();
    set_instr(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_wb(input logic [4:0] rd, input logic [31:0] v, input logic z);
    wb_t e;
    e.rd = rd; e.value = v; e.zero = z;
    wb_q.push_back(e);
  endtask

  // Monitor: compare every retired writeback and every print pop.
  always @(negedge clock) begin
    if (reset === 1'b1 && r_wb_RegWrite === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: got retire rd=%0d value=%h, required none", r_wb_rd, r_wb_value);
      end else begin
        mon_wb = wb_q.pop_front();
        check("wb_rd", 32'(r_wb_rd), 32'(mon_wb.rd));
        check("wb_value", r_wb_value, mon_wb.value);
        check("wb_aluzero", 32'(r_wb_aluzero), 32'(mon_wb.zero));
      end
    end
    if (reset === 1'b1 && print_valid === 1'b1 && print_ready === 1'b1) begin
      if (pr_q.size() == 0) begin
        n_total++;
        $display("FAIL print_unexpected: got pop data=%h, required none", print_data);
      end else begin
        mon_pr = pr_q.pop_front();
        check("print_data", print_data, mon_pr);
      end
    end
  end

  initial begin
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0; print_ready = 1'b0;
    nop();
    r_me_MemRead = 1'b1;
    #12;
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    check("rst_wb_rd", 32'(r_wb_rd), 32'h0);
    check("rst_wb_value", r_wb_value, 32'h0);
    check("rst_wb_regwrite", 32'(r_wb_RegWrite), 32'h0);
    check("rst_print_valid", 32'(print_valid), 32'h0);
    check("rst_print_data", print_data, 32'h0);
    nop();
    #1 reset = 1'b1;
    cyc();

    // ALU op, one-cycle latency.
    set_instr(5'd3, 32'h2A, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_wb(5'd3, 32'h2A, 1'b0);
    @(negedge clock); check("alu_stall", 32'(stall_o), 32'h0);
    cyc(); nop();
    @(negedge clock); check("alu_no_req", 32'(dmem_req), 32'h0);
    cyc();

    // Load acked on the third request cycle.
    set_instr(5'd5, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      @(negedge clock);
      check("load_req", 32'(dmem_req), 32'h1);
      check("load_addr", dmem_addr, 32'h100);
      check("load_we", 32'(dmem_we), 32'h0);
      check("load_stall", 32'(stall_o), (i < 2) ? 32'h1 : 32'h0);
      if (i > 0) check("load_bubble", 32'(r_wb_RegWrite), 32'h0);
      cyc();
    end
    exp_wb(5'd5, 32'hDEADBEEF, 1'b0);
    nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clock); check("load_req_drop", 32'(dmem_req), 32'h0);
    cyc();

    // Store with zero-wait ack, then a read+write treated as a store.
    set_instr(5'd0, 32'h40, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    dmem_ack = 1'b1;
    @(negedge clock);
    check("st_req", 32'(dmem_req), 32'h1);
    check("st_we", 32'(dmem_we), 32'h1);
    check("st_addr", dmem_addr, 32'h40);
    check("st_wdata", dmem_wdata, 32'h55);
    check("st_stall", 32'(stall_o), 32'h0);
    cyc();
    set_instr(5'd7, 32'h80, 1'b1, 32'h9, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_rdata = 32'h1234;
    exp_wb(5'd7, 32'h80, 1'b1);
    @(negedge clock);
    check("rw_we", 32'(dmem_we), 32'h1);
    check("rw_stall", 32'(stall_o), 32'h0);
    cyc(); nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clock); check("st_req_drop", 32'(dmem_req), 32'h0);
    cyc();

    // Five prints into a 4-deep FIFO with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      set_instr(5'd0, 32'h10 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      pr_q.push_back(32'h10 + 32'(i));
      @(negedge clock); check("pr_fill_stall", 32'(stall_o), 32'h0);
      cyc();
    end
    set_instr(5'd0, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("pr_full_stall", 32'(stall_o), 32'h1);
      check("pr_head_stable", print_data, 32'h10);
      cyc();
    end
    print_ready = 1'b1;
    pr_q.push_back(32'h14);
    @(negedge clock); check("pr_swap_stall", 32'(stall_o), 32'h0);
    cyc();
    print_ready = 1'b0;
    set_instr(5'd0, 32'h15, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check("pr_still_full", 32'(stall_o), 32'h1);
    check("pr_head_next", print_data, 32'h11);
    cyc();
    print_ready = 1'b1;
    pr_q.push_back(32'h15);
    @(negedge clock); check("pr_swap2_stall", 32'(stall_o), 32'h0);
    cyc(); nop();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); cyc();
    end
    @(negedge clock); check("pr_drained", 32'(print_valid), 32'h0);
    // Push into an empty FIFO while ready is high: nothing popped this cycle.
    set_instr(5'd0, 32'h99, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    pr_q.push_back(32'h99);
    cyc(); nop();
    @(negedge clock);
    check("pr_empty_push_valid", 32'(print_valid), 32'h1);
    cyc();
    @(negedge clock); check("pr_empty_after", 32'(print_valid), 32'h0);
    print_ready = 1'b0;
    cyc();

    // Load+print acked while the FIFO is full: result latched, no re-request.
    for (int i = 0; i < 4; i++) begin
      set_instr(5'd0, 32'h20 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      pr_q.push_back(32'h20 + 32'(i));
      cyc();
    end
    set_instr(5'd4, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
    @(negedge clock);
    check("done_req", 32'(dmem_req), 32'h1);
    check("done_stall", 32'(stall_o), 32'h1);
    cyc(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clock);
    check("done_no_rereq", 32'(dmem_req), 32'h0);
    check("done_stall2", 32'(stall_o), 32'h1);
    cyc();
    print_ready = 1'b1;
    pr_q.push_back(32'hCAFE0001);
    exp_wb(5'd4, 32'hCAFE0001, 1'b0);
    @(negedge clock); check("done_retire", 32'(stall_o), 32'h0);
    cyc(); nop();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); cyc();
    end
    print_ready = 1'b0;

    // Reset while waiting for an ack.
    set_instr(5'd9, 32'h77, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_wb(5'd9, 32'h77, 1'b0);
    cyc();
    set_instr(5'd2, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clock); cyc();
    @(negedge clock);
    check("wait_req", 32'(dmem_req), 32'h1);
    check("wait_wb_hold", r_wb_value, 32'h77);
    #1 reset = 1'b0;
    #1;
    check("rst_wait_req", 32'(dmem_req), 32'h0);
    check("rst_wait_value", r_wb_value, 32'h0);
    check("rst_wait_rd", 32'(r_wb_rd), 32'h0);
    nop();
    cyc();
    reset = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h5555;
    @(negedge clock);
    check("late_ack_req", 32'(dmem_req), 32'h0);
    check("late_ack_stall", 32'(stall_o), 32'h0);
    cyc(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clock); check("late_ack_no_retire", 32'(r_wb_RegWrite), 32'h0);
    cyc();

`ifdef STG_ME_ACK_TIMEOUT_EN
    // Watchdog: no ack ever arrives.
    begin
      int stalls;
      stalls = 0;
      check("tmo_err_init", 32'(mem_err), 32'h0);
      set_instr(5'd6, 32'h400, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (stall_o !== 1'b1) break;
        stalls++;
        cyc();
      end
      check("tmo_stall_cycles", 32'(stalls), 32'd16);
      cyc(); nop();
      @(negedge clock);
      check("tmo_err", 32'(mem_err), 32'h1);
      check("tmo_bubble", 32'(r_wb_RegWrite), 32'h0);
      check("tmo_no_push", 32'(print_valid), 32'h0);
      dmem_ack = 1'b1; dmem_rdata = 32'h1;
      cyc(); dmem_ack = 1'b0;
      @(negedge clock);
      check("tmo_late_ack", 32'(r_wb_RegWrite), 32'h0);
      check("tmo_err_sticky", 32'(mem_err), 32'h1);
      cyc();
    end
`endif

    check("wb_queue_empty", 32'(wb_q.size()), 32'h0);
    check("print_queue_empty", 32'(pr_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stg_4_me.md
Name: stg_4_ME

Overview:
- Memory stage of the in-order pipeline.
- Consumes the EX→ME pipeline registers (r_me_*) and performs the data-memory access over a req/ack handshake.
- Buffers print values in a small FIFO drained by a valid/ready print port.
- Produces the ME→WB pipeline registers (r_wb_*), and raises a stall to upstream stages while a memory access or print push cannot complete.

Parameters:
- VALUE_W, 32, data/value width.
- REG_ADDR_W, 5, register-file address width.
- PRINT_DEPTH, 4, print FIFO entries (power of two, ≥2).
- TIMEOUT_CYC, 16, ack watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low.
- r_me_rd  in  REG_ADDR_W  destination register.
- r_me_aluout  in  VALUE_W  ALU result; memory address for loads/stores.
- r_me_aluzero  in  1  ALU zero flag, passed through.
- r_me_store  in  VALUE_W  store data.
- r_me_RegWrite  in  1  writeback enable.
- r_me_PrintValue  in  1  print request.
- r_me_MemRead  in  1  load.
- r_me_MemWrite  in  1  store.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write.
- dmem_addr  out  VALUE_W  =r_me_aluout.
- dmem_wdata  out  VALUE_W  =r_me_store.
- dmem_ack  in  1  access complete; rdata valid this cycle for reads.
- dmem_rdata  in  VALUE_W  read data.
- stall_o  out  1  upstream must hold r_me_* and earlier stages.
- print_valid  out  1  FIFO head valid.
- print_data  out  VALUE_W  FIFO head.
- print_ready  in  1  consumer accepts head.
- r_wb_rd  out  REG_ADDR_W  registered.
- r_wb_value  out  VALUE_W  registered; rdata for loads, aluout otherwise.
- r_wb_aluzero  out  1  registered.
- r_wb_RegWrite  out  1  registered.

Behaviour:
- Reset: all r_wb_* = 0; FSM = IDLE; FIFO empty (print_valid=0, print_data=0); dmem_req=0.
- mem_op = MemRead | MemWrite. If both are set, treat as MemWrite: dmem_we=1 and no load data returned.
- FSM has two states, IDLE and WAIT:
  - IDLE: if mem_op, assert dmem_req combinationally. If dmem_ack arrives the same cycle, retire at this edge (zero-wait memory). Otherwise go to WAIT.
  - WAIT: hold dmem_req=1 with the same we/addr/wdata until dmem_ack. On ack, retire and return to IDLE.
- A non-memory instruction retires in the cycle it is presented (1-cycle latency to r_wb_*).
- print_block = PrintValue & FIFO full & !(print_valid & print_ready). A pop in the same cycle frees the slot.
- stall_o = (mem_op & !dmem_ack) | print_block.
- Retire (stall_o=0 at the edge):
  - r_wb_* load from the current instruction.
  - If PrintValue, push the writeback value into the FIFO.
- Stall cycle:
  - r_wb_RegWrite<=0, i.e. a bubble; the other r_wb_* fields hold.
  - No FIFO push.
  - A mem access that completes while print_block is high is latched; it is not re-issued. Hold the ack'd rdata internally and set a done flag so no second request is issued. Clear the flag on retire.
- FIFO:
  - Circular buffer with rd/wr pointers that wrap at PRINT_DEPTH; count ranges 0..PRINT_DEPTH.
  - Push and pop in the same cycle keep count unchanged. This is legal when full (with a pop) and when empty: an empty FIFO pops nothing, and the pushed value appears at the head next cycle.
  - Pop occurs when print_valid & print_ready.
  - print_data is the head; it is stable while print_valid=1 and print_ready=0.
- Reset mid-access: everything returns to reset state immediately; the outstanding request is dropped and dmem_req deasserts asynchronously.

Optional Feature:
- Macro STG_ME_ACK_TIMEOUT_EN.
- Defined:
  - Adds output mem_err (1 bit, sticky, reset 0).
  - A counter increments each WAIT cycle. On reaching TIMEOUT_CYC without ack, abort: mem_err<=1, return to IDLE, and retire the instruction with r_wb_RegWrite=0 and no print push.
  - A late ack after abort is ignored.
- Not defined: WAIT persists indefinitely; there is no mem_err port and no counter logic.

Test Plan:
- ALU op: rd=3, aluout=0x2A, RegWrite=1, no mem → next edge r_wb_rd=3, r_wb_value=0x2A, r_wb_RegWrite=1; stall_o never high.
- Load, ack after 3 cycles with rdata=0xDEADBEEF, addr 0x100 → dmem_req high 3 cycles with dmem_addr=0x100; stall_o high 2 cycles; then r_wb_value=0xDEADBEEF; the stall cycles produce bubbles with RegWrite=0.
- Store, zero-wait ack: addr 0x40, wdata 0x55 → dmem_we=1 for one cycle; no stall; retire the same cycle.
- Print ×5 with DEPTH=4 and print_ready=0 → 4 pushes; the 5th stalls. Raise print_ready for one cycle → the 5th pushes that cycle and count stays 4. Data drains in order.
- Reset asserted in WAIT → dmem_req=0 and r_wb_*=0 at once; a subsequent ack causes no retire.
- With STG_ME_ACK_TIMEOUT_EN and TIMEOUT_CYC=16, no ack → mem_err=1 after 16 WAIT cycles; the instruction retires with RegWrite=0; a later ack is ignored.
